// File: rtl/hazard_pkg.sv
// Shared types and defaults for the RAW hazard tracker.
// Entry record is sized for the widest supported register address.
package hazard_pkg;

  localparam int HZ_AW_DEF    = 3;
  localparam int HZ_NSRC_DEF  = 2;
  localparam int HZ_DEPTH_DEF = 3;
  localparam int HZ_AW_MAX    = 8;

  typedef struct packed {
    logic                 valid;
    logic [HZ_AW_MAX-1:0] rd;
    logic                 wr;
    logic                 ld;
  } hz_entry_t;

  function automatic logic hz_live(hz_entry_t e);
    return e.valid && e.wr;
  endfunction

endpackage

// File: rtl/hazard_src_match.sv
// One decode source operand compared against one in-flight writer.
// Register 0 can be made hazard-free for hardwired-zero register files.
module hazard_src_match
  import hazard_pkg::*;
#(
  parameter int AW      = HZ_AW_DEF,
  parameter bit R0_ZERO = 1'b0
) (
  input  logic          id_valid,
  input  logic          used,
  input  logic [AW-1:0] rs,
  input  hz_entry_t     ent,
  output logic          match
);

  logic [HZ_AW_MAX-1:0] rs_x;
  logic                 zero_kill;

  assign rs_x      = HZ_AW_MAX'(rs);
  assign zero_kill = R0_ZERO && (rs == '0);

  assign match = id_valid && used
              && hz_live(ent)
              && (ent.rd == rs_x)
              && !zero_kill;

endmodule

// File: rtl/hazard_stall_tracker.sv
// RAW hazard detector: shift record of in-flight writers,
// decode stall generation and a saturating stall counter.
module hazard_stall_tracker
  import hazard_pkg::*;
#(
  parameter int AW      = HZ_AW_DEF,
  parameter int NSRC    = HZ_NSRC_DEF,
  parameter int DEPTH   = HZ_DEPTH_DEF,
  parameter bit BYPASS  = 1'b0,
  parameter bit R0_ZERO = 1'b0,
  parameter int CW      = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  input  logic [NSRC*AW-1:0] id_rs,
  input  logic [NSRC-1:0]    id_rs_used,
  input  logic [AW-1:0]      id_rd,
  input  logic               id_rd_write,
  input  logic               id_is_load,
  input  logic               advance,
  input  logic [DEPTH:0]     flush_mask,
  output logic               stall,
  output logic [NSRC-1:0]    stall_src,
  output logic [CW-1:0]      stall_count
);

  hz_entry_t ent_q [DEPTH];
  hz_entry_t ent_d [DEPTH];
  logic [CW-1:0] cnt_q, cnt_d;

  logic [NSRC*DEPTH-1:0] hit;
  logic [NSRC-1:0]       src_raw;

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    for (genvar k = 0; k < DEPTH; k++) begin : g_ent
      hazard_src_match #(
        .AW      (AW),
        .R0_ZERO (R0_ZERO)
      ) u_match (
        .id_valid (id_valid),
        .used     (id_rs_used[i]),
        .rs       (id_rs[i*AW +: AW]),
        .ent      (ent_q[k]),
        .match    (hit[i*DEPTH+k])
      );
    end
  end

  // With forwarding only a load still in ID/EX cannot be bypassed.
  always_comb begin
    src_raw = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (BYPASS)
        src_raw[i] = hit[i*DEPTH] && ent_q[0].ld;
      else
        src_raw[i] = |hit[i*DEPTH +: DEPTH];
    end
  end

  assign stall_src   = flush_mask[0] ? '0 : src_raw;
  assign stall       = |stall_src;
  assign stall_count = cnt_q;

  always_comb begin
    for (int k = 0; k < DEPTH; k++)
      ent_d[k] = ent_q[k];
    if (advance) begin
      for (int k = DEPTH-1; k > 0; k--) begin
        ent_d[k]       = ent_q[k-1];
        ent_d[k].valid = ent_q[k-1].valid && !flush_mask[k];
      end
      ent_d[0].valid = id_valid && !stall && !flush_mask[0];
      ent_d[0].rd    = HZ_AW_MAX'(id_rd);
      ent_d[0].wr    = id_rd_write;
      ent_d[0].ld    = id_is_load;
    end else begin
      for (int k = 0; k < DEPTH; k++)
        if (flush_mask[k+1])
          ent_d[k].valid = 1'b0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall && advance && (cnt_q != {CW{1'b1}}))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++)
        ent_q[k] <= '0;
      cnt_q <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++)
        ent_q[k] <= ent_d[k];
      cnt_q <= cnt_d;
    end
  end

endmodule
